// File: rtl/store_unit.sv
// Store unit: turns a core SB/SH/SW request into a single-beat bus write with
// lane-replicated data, byte strobes and a bounded wait for the write response.
module store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        st_req_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic        misalign_o,
  output logic        bus_valid_o,
  input  logic        bus_ready_i,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  // The counter holds the number of RESP cycles already spent, so the last
  // allowed cycle is the one where it equals TIMEOUT_CYCLES-1.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StAddr, StResp, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  logic            legal;
  logic [31:0]     lane_data;
  logic [3:0]      lane_strb;

  always_comb begin
    legal     = 1'b0;
    lane_data = '0;
    lane_strb = '0;
    case (funct3_i)
      3'b000: begin
        legal     = 1'b1;
        lane_data = {4{wdata_i[7:0]}};
        lane_strb = 4'b0001 << addr_i[1:0];
      end
      3'b001: begin
        legal     = ~addr_i[0];
        lane_data = {2{wdata_i[15:0]}};
        lane_strb = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        legal     = (addr_i[1:0] == 2'b00);
        lane_data = wdata_i;
        lane_strb = 4'b1111;
      end
      default: ;
    endcase
  end

  assign misalign_o = (state_q == StIdle) && st_req_i && !legal;
  assign stall_o    = (state_q == StAddr) || (state_q == StResp) ||
                      ((state_q == StIdle) && st_req_i && legal);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bus_valid_o <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_wstrb_o <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (st_req_i && legal) begin
            bus_addr_o  <= {addr_i[31:2], 2'b00};
            bus_wdata_o <= lane_data;
            bus_wstrb_o <= lane_strb;
            bus_valid_o <= 1'b1;
            state_q     <= StAddr;
          end
        end
        StAddr: begin
          if (bus_ready_i) begin
            bus_valid_o <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (bus_ack_i) begin
            done_o  <= 1'b1;
            err_o   <= bus_err_i;
            state_q <= StDone;
          end else if (cnt_q == CntLast) begin
            done_o  <= 1'b1;
            err_o   <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q     <= StIdle;
          bus_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: stimulus pushes expected bus beats and
// completions into queues; a negedge monitor pops and compares them.
module tb_store_unit;

  localparam int unsigned Timeout = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic        stall;
  logic        done;
  logic        err;
  logic        misalign;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic        bus_err;

  store_unit #(.TIMEOUT_CYCLES(Timeout)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .st_req_i    (st_req),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .funct3_i    (funct3),
    .stall_o     (stall),
    .done_o      (done),
    .err_o       (err),
    .misalign_o  (misalign),
    .bus_valid_o (bus_valid),
    .bus_ready_i (bus_ready),
    .bus_addr_o  (bus_addr),
    .bus_wdata_o (bus_wdata),
    .bus_wstrb_o (bus_wstrb),
    .bus_ack_i   (bus_ack),
    .bus_err_i   (bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  typedef struct {
    logic err;
    int   cyc;
  } done_t;

  bus_t  bus_q[$];
  done_t done_q[$];
  bus_t  be;
  done_t de;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic fail(input string name, input string msg);
    n_total++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Monitor: every bus handshake and every done pulse must match a queued expectation.
  always @(negedge clk) begin
    if (bus_valid && bus_ready) begin
      if (bus_q.size() == 0) fail("bus_unexpected", "handshake with nothing expected");
      else begin
        be = bus_q.pop_front();
        check("bus_addr", bus_addr, be.addr);
        check("bus_wdata", bus_wdata, be.wdata);
        check("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, be.wstrb});
      end
    end
    if (done) begin
      if (done_q.size() == 0) fail("done_unexpected", "done_o with nothing expected");
      else begin
        de = done_q.pop_front();
        check("done_err", err, de.err);
        check("done_cycle", cyc, de.cyc);
      end
    end
  end

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] es,
                          input int rdly, input int adly, input logic berr, input logic noack,
                          input logic eerr);
    int    c0;
    int    resp;
    bus_t  eb;
    done_t ed_e;
    logic  got;
    @(posedge clk); #1;
    funct3 = f3; addr = a; wdata = d; st_req = 1'b1;
    c0   = cyc;
    resp = noack ? int'(Timeout) : adly + 1;
    eb.addr = ea; eb.wdata = ed; eb.wstrb = es;
    bus_q.push_back(eb);
    ed_e.err = eerr; ed_e.cyc = c0 + 2 + rdly + resp;
    done_q.push_back(ed_e);
    @(negedge clk);
    check("stall_idle_req", stall, 1);
    check("misalign_legal", misalign, 0);
    @(posedge clk); #1;
    // Inputs outside IDLE must not disturb the registered beat.
    addr = ~a; wdata = ~d; funct3 = 3'b111;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      check("addr_valid", bus_valid, 1);
      check("addr_stable_a", bus_addr, ea);
      check("addr_stable_d", bus_wdata, ed);
      check("addr_stable_s", {28'd0, bus_wstrb}, {28'd0, es});
      @(posedge clk); #1;
    end
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    if (!noack) begin
      for (int i = 0; i < adly; i++) begin
        @(posedge clk); #1;
      end
      bus_ack = 1'b1; bus_err = berr;
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_err = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < int'(Timeout) + 20 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    if (!got) fail("done_wait", "no done_o within bound");
    else check("stall_done", stall, 0);
    @(posedge clk); #1;
    st_req = 1'b0;
  endtask

  task automatic do_bad(input logic [2:0] f3, input logic [31:0] a);
    @(posedge clk); #1;
    funct3 = f3; addr = a; wdata = 32'h5555_AAAA; st_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bad_misalign", misalign, 1);
      check("bad_stall", stall, 0);
      check("bad_valid", bus_valid, 0);
    end
    @(posedge clk); #1;
    st_req = 1'b0;
    @(negedge clk);
    check("bad_misalign_clr", misalign, 0);
  endtask

  initial begin
    bus_t eb;
    rst = 1'b1; st_req = 1'b0; addr = '0; wdata = '0; funct3 = '0;
    bus_ready = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", bus_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_stall", stall, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_wstrb", {28'd0, bus_wstrb}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // f3, addr, wdata, exp addr, exp wdata, exp strb, ready dly, ack dly, bus_err, noack, exp err
    do_store(3'b010, 32'h100, 32'hDEAD_BEEF, 32'h100, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0, 0, 0);
    do_store(3'b000, 32'h203, 32'h0000_00A5, 32'h200, 32'hA5A5_A5A5, 4'b1000, 0, 0, 0, 0, 0);
    do_store(3'b001, 32'h202, 32'h0000_1234, 32'h200, 32'h1234_1234, 4'b1100, 3, 0, 0, 0, 0);
    do_store(3'b000, 32'h401, 32'h7766_5511, 32'h400, 32'h1111_1111, 4'b0010, 1, 2, 0, 0, 0);
    do_store(3'b001, 32'h500, 32'hCAFE_BEEF, 32'h500, 32'hBEEF_BEEF, 4'b0011, 0, 1, 0, 0, 0);

    do_bad(3'b010, 32'h102);
    do_bad(3'b011, 32'h100);
    do_bad(3'b001, 32'h201);

    do_store(3'b010, 32'h600, 32'h0BAD_F00D, 32'h600, 32'h0BAD_F00D, 4'b1111, 0, 0, 0, 1, 1);
    do_store(3'b010, 32'h604, 32'h1357_9BDF, 32'h604, 32'h1357_9BDF, 4'b1111, 0, 0, 1, 0, 1);

    // Reset in RESP, then a stale ack: no done_o may appear.
    @(posedge clk); #1;
    funct3 = 3'b010; addr = 32'h300; wdata = 32'h1122_3344; st_req = 1'b1;
    eb.addr = 32'h300; eb.wdata = 32'h1122_3344; eb.wstrb = 4'b1111;
    bus_q.push_back(eb);
    @(posedge clk); #1;
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    @(negedge clk);
    check("resp_stall", stall, 1);
    @(posedge clk); #1;
    rst = 1'b1; st_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_addr", bus_addr, 0);
    check("abort_wstrb", {28'd0, bus_wstrb}, 0);
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_err = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_stall", stall, 0);
      check("abort_valid", bus_valid, 0);
      check("abort_done", done, 0);
    end

    // A fresh store after the abort still works.
    do_store(3'b000, 32'h700, 32'h0000_003C, 32'h700, 32'h3C3C_3C3C, 4'b0001, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    check("bus_q_empty", bus_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
